// File: rtl/memory_stage.sv
// memory_stage: RV32I load/store stage between execute and writeback, driving a req/ack data memory.
// Define MISALIGN_TRAP_EN to add ms_o_misaligned and trap misaligned half/word accesses without a bus request.
module memory_stage #(
  parameter int DWIDTH      = 32,
  parameter int AWIDTH      = 5,
  parameter int FUNCT_WIDTH = 3
) (
  input  logic                   ms_clk,
  input  logic                   ms_rst,
  input  logic                   ms_i_ce,
  input  logic                   ms_i_stall,
  input  logic                   ms_i_flush,
  input  logic [6:0]             ms_i_opcode,
  input  logic [FUNCT_WIDTH-1:0] ms_i_funct3,
  input  logic [DWIDTH-1:0]      ms_i_alu_value,
  input  logic [DWIDTH-1:0]      ms_i_data_rs2,
  input  logic [AWIDTH-1:0]      ms_i_addr_rd,
  input  logic                   ms_i_we_reg,
  output logic                   ms_o_req,
  output logic                   ms_o_we,
  output logic [DWIDTH-1:0]      ms_o_addr,
  output logic [DWIDTH-1:0]      ms_o_wdata,
  output logic [3:0]             ms_o_wsel,
  input  logic                   ms_i_ack,
  input  logic [DWIDTH-1:0]      ms_i_rdata,
  output logic                   ms_o_valid,
  output logic                   ms_o_we_reg,
  output logic [AWIDTH-1:0]      ms_o_addr_rd,
  output logic [DWIDTH-1:0]      ms_o_data_rd,
  output logic                   ms_o_ce,
  output logic                   ms_o_stall
`ifdef MISALIGN_TRAP_EN
  ,
  output logic                   ms_o_misaligned
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_nxt;

  logic                   is_load, is_store, is_mem, accept, misalign;
  logic [DWIDTH-1:0]      st_wdata;
  logic [3:0]             st_wsel;
  logic [7:0]             ld_byte;
  logic [15:0]            ld_half;
  logic [DWIDTH-1:0]      ld_data;
  logic                   valid_r, we_reg_r, flushed_r, is_load_r, ld_we_r;
  logic [FUNCT_WIDTH-1:0] funct3_r;
  logic [1:0]             lane_r;

  assign is_load  = (ms_i_opcode == 7'b0000011);
  assign is_store = (ms_i_opcode == 7'b0100011);
  assign is_mem   = is_load | is_store;
  assign accept   = (state == IDLE) & ms_i_ce & ~ms_o_stall & ~ms_i_flush;

`ifdef MISALIGN_TRAP_EN
  assign misalign = (is_load & (ms_i_funct3[1:0] == 2'b01) & ms_i_alu_value[0])
                  | (is_store & (ms_i_funct3 == 3'b001) & ms_i_alu_value[0])
                  | (is_mem & (ms_i_funct3 == 3'b010) & (ms_i_alu_value[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign ms_o_stall  = ms_i_stall | (state != IDLE);
  assign ms_o_valid  = valid_r & ~ms_i_flush;
  assign ms_o_we_reg = we_reg_r & ~ms_i_flush;
  assign ms_o_ce     = ms_o_valid;

  always_comb begin
    st_wdata = ms_i_data_rs2;
    st_wsel  = 4'b1111;
    case (ms_i_funct3)
      3'b000: begin
        st_wdata = {4{ms_i_data_rs2[7:0]}};
        st_wsel  = 4'b0001 << ms_i_alu_value[1:0];
      end
      3'b001: begin
        st_wdata = {2{ms_i_data_rs2[15:0]}};
        st_wsel  = 4'b0011 << {ms_i_alu_value[1], 1'b0};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = ms_i_rdata[{lane_r, 3'b000} +: 8];
    ld_half = lane_r[1] ? ms_i_rdata[31:16] : ms_i_rdata[15:0];
    case (funct3_r)
      3'b000:  ld_data = {{(DWIDTH-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {{(DWIDTH-8){1'b0}}, ld_byte};
      3'b001:  ld_data = {{(DWIDTH-16){ld_half[15]}}, ld_half};
      3'b101:  ld_data = {{(DWIDTH-16){1'b0}}, ld_half};
      default: ld_data = ms_i_rdata;
    endcase
  end

  always_ff @(posedge ms_clk or negedge ms_rst) begin
    if (!ms_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  // A flushed bus transaction still runs to ack, then bypasses DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (is_mem && !misalign) ? BUSY : DONE;
      BUSY:    if (ms_i_ack) state_nxt = (flushed_r || ms_i_flush) ? IDLE : DONE;
      DONE:    if (!ms_i_stall) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ms_clk or negedge ms_rst) begin
    if (!ms_rst) begin
      ms_o_req     <= 1'b0;
      ms_o_we      <= 1'b0;
      ms_o_addr    <= '0;
      ms_o_wdata   <= '0;
      ms_o_wsel    <= '0;
      ms_o_addr_rd <= '0;
      ms_o_data_rd <= '0;
      valid_r      <= 1'b0;
      we_reg_r     <= 1'b0;
      flushed_r    <= 1'b0;
      is_load_r    <= 1'b0;
      ld_we_r      <= 1'b0;
      funct3_r     <= '0;
      lane_r       <= '0;
    end else begin
      case (state)
        IDLE: begin
          flushed_r <= 1'b0;
          if (accept) begin
            ms_o_addr_rd <= ms_i_addr_rd;
            funct3_r     <= ms_i_funct3;
            lane_r       <= ms_i_alu_value[1:0];
            is_load_r    <= is_load;
            ld_we_r      <= ms_i_we_reg;
            if (is_mem && !misalign) begin
              ms_o_req   <= 1'b1;
              ms_o_we    <= is_store;
              ms_o_addr  <= {ms_i_alu_value[DWIDTH-1:2], 2'b00};
              ms_o_wdata <= st_wdata;
              ms_o_wsel  <= st_wsel;
            end else begin
              valid_r      <= 1'b1;
              we_reg_r     <= ms_i_we_reg & ~misalign;
              ms_o_data_rd <= misalign ? '0 : ms_i_alu_value;
            end
          end
        end
        BUSY: begin
          if (ms_i_flush) flushed_r <= 1'b1;
          if (ms_i_ack) begin
            ms_o_req <= 1'b0;
            ms_o_we  <= 1'b0;
            if (!(flushed_r || ms_i_flush)) begin
              valid_r      <= 1'b1;
              we_reg_r     <= is_load_r & ld_we_r;
              ms_o_data_rd <= is_load_r ? ld_data : '0;
            end
          end
        end
        DONE: begin
          if (!ms_i_stall) begin
            valid_r  <= 1'b0;
            we_reg_r <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic mis_r;

  always_ff @(posedge ms_clk or negedge ms_rst) begin
    if (!ms_rst)                           mis_r <= 1'b0;
    else if (state == IDLE)                mis_r <= accept & misalign;
    else if (state == DONE && !ms_i_stall) mis_r <= 1'b0;
  end

  assign ms_o_misaligned = mis_r;
`endif

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: randomized load/store/ALU traffic against a transaction-level model of memory_stage.
module tb_memory_stage;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ADD   = 7'b0110011;

  logic        ms_clk = 1'b0;
  logic        ms_rst;
  logic        ms_i_ce, ms_i_stall, ms_i_flush, ms_i_we_reg, ms_i_ack;
  logic [6:0]  ms_i_opcode;
  logic [2:0]  ms_i_funct3;
  logic [31:0] ms_i_alu_value, ms_i_data_rs2, ms_i_rdata;
  logic [4:0]  ms_i_addr_rd;
  logic        ms_o_req, ms_o_we, ms_o_valid, ms_o_we_reg, ms_o_ce, ms_o_stall;
  logic [31:0] ms_o_addr, ms_o_wdata, ms_o_data_rd;
  logic [3:0]  ms_o_wsel;
  logic [4:0]  ms_o_addr_rd;
`ifdef MISALIGN_TRAP_EN
  logic        ms_o_misaligned;
  bit          exp_mis = 1'b0;
`endif

  memory_stage #(.DWIDTH(32), .AWIDTH(5), .FUNCT_WIDTH(3)) dut (
    .ms_clk(ms_clk), .ms_rst(ms_rst), .ms_i_ce(ms_i_ce), .ms_i_stall(ms_i_stall),
    .ms_i_flush(ms_i_flush), .ms_i_opcode(ms_i_opcode), .ms_i_funct3(ms_i_funct3),
    .ms_i_alu_value(ms_i_alu_value), .ms_i_data_rs2(ms_i_data_rs2), .ms_i_addr_rd(ms_i_addr_rd),
    .ms_i_we_reg(ms_i_we_reg), .ms_o_req(ms_o_req), .ms_o_we(ms_o_we), .ms_o_addr(ms_o_addr),
    .ms_o_wdata(ms_o_wdata), .ms_o_wsel(ms_o_wsel), .ms_i_ack(ms_i_ack), .ms_i_rdata(ms_i_rdata),
    .ms_o_valid(ms_o_valid), .ms_o_we_reg(ms_o_we_reg), .ms_o_addr_rd(ms_o_addr_rd),
    .ms_o_data_rd(ms_o_data_rd), .ms_o_ce(ms_o_ce), .ms_o_stall(ms_o_stall)
`ifdef MISALIGN_TRAP_EN
    , .ms_o_misaligned(ms_o_misaligned)
`endif
  );

  always #5 ms_clk = ~ms_clk;

  // Expected outputs for the current cycle, written by the stimulus process.
  bit          exp_reset = 1'b1;
  bit          exp_stall, exp_valid, exp_we_reg, exp_req, exp_mwe, exp_data_chk;
  logic [4:0]  exp_rd;
  logic [31:0] exp_data, exp_maddr, exp_wdata;
  logic [3:0]  exp_wsel;
  bit          want_data, want_req, want_st, pin_data_en, pin_req_en, pin_st_en;
  logic [31:0] want_data_val, want_addr, want_wdata;
  logic [3:0]  want_wsel;
  int unsigned vectors = 0, miscompares = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge ms_clk) begin
    if (exp_reset) begin
      cmp("rst_req", 32'(ms_o_req), 32'd0);
      cmp("rst_we", 32'(ms_o_we), 32'd0);
      cmp("rst_addr", ms_o_addr, 32'd0);
      cmp("rst_wdata", ms_o_wdata, 32'd0);
      cmp("rst_wsel", 32'(ms_o_wsel), 32'd0);
      cmp("rst_valid", 32'(ms_o_valid), 32'd0);
      cmp("rst_we_reg", 32'(ms_o_we_reg), 32'd0);
      cmp("rst_addr_rd", 32'(ms_o_addr_rd), 32'd0);
      cmp("rst_data_rd", ms_o_data_rd, 32'd0);
      cmp("rst_ce", 32'(ms_o_ce), 32'd0);
      cmp("rst_stall", 32'(ms_o_stall), 32'd0);
`ifdef MISALIGN_TRAP_EN
      cmp("rst_misaligned", 32'(ms_o_misaligned), 32'd0);
`endif
    end else begin
      cmp("stall", 32'(ms_o_stall), 32'(exp_stall));
      cmp("valid", 32'(ms_o_valid), 32'(exp_valid));
      cmp("we_reg", 32'(ms_o_we_reg), 32'(exp_we_reg));
      cmp("req", 32'(ms_o_req), 32'(exp_req));
`ifdef MISALIGN_TRAP_EN
      cmp("misaligned", 32'(ms_o_misaligned), 32'(exp_mis));
`endif
      if (exp_valid) cmp("addr_rd", 32'(ms_o_addr_rd), 32'(exp_rd));
      if (exp_data_chk) cmp("data_rd", ms_o_data_rd, exp_data);
      if (exp_req) begin
        cmp("mem_addr", ms_o_addr, exp_maddr);
        cmp("mem_we", 32'(ms_o_we), 32'(exp_mwe));
        if (exp_mwe) begin
          cmp("mem_wdata", ms_o_wdata, exp_wdata);
          cmp("mem_wsel", 32'(ms_o_wsel), 32'(exp_wsel));
        end
      end
      if (pin_data_en) cmp("pin_data_rd", ms_o_data_rd, want_data_val);
      if (pin_req_en) cmp("pin_mem_addr", ms_o_addr, want_addr);
      if (pin_st_en) begin
        cmp("pin_wdata", ms_o_wdata, want_wdata);
        cmp("pin_wsel", 32'(ms_o_wsel), 32'(want_wsel));
      end
    end
  end

  function automatic logic [31:0] m_load(input logic [31:0] word, input logic [2:0] fn, input logic [31:0] a);
    int unsigned lane;
    logic [31:0] b, h;
    lane = a % 4;
    b = (word >> (8 * lane)) & 32'hFF;
    h = (word >> (16 * (lane / 2))) & 32'hFFFF;
    case (fn)
      3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? h - 32'h10000 : h;
      3'd5:    return h;
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] fn, input logic [31:0] d);
    if (fn == 3'd0) return (d & 32'hFF) * 32'h01010101;
    if (fn == 3'd1) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [3:0] m_wsel(input logic [2:0] fn, input logic [31:0] a);
    int unsigned lane;
    lane = a % 4;
    if (fn == 3'd0) return 4'(1 << lane);
    if (fn == 3'd1) return 4'(3 << (2 * (lane / 2)));
    return 4'hF;
  endfunction

`ifdef MISALIGN_TRAP_EN
  function automatic bit m_misaligned(input bit ld, input bit st, input logic [2:0] fn, input logic [31:0] a);
    bit half, word;
    half = (ld && (fn == 3'd1 || fn == 3'd5)) || (st && fn == 3'd1);
    word = (ld || st) && fn == 3'd2;
    return (half && (a % 2 != 0)) || (word && (a % 4 != 0));
  endfunction
`endif

  task automatic tick();
    @(posedge ms_clk);
    #1;
  endtask

  task automatic expect_quiet(input bit s);
    exp_stall = s; exp_valid = 0; exp_we_reg = 0; exp_req = 0; exp_data_chk = 0;
`ifdef MISALIGN_TRAP_EN
    exp_mis = 0;
`endif
  endtask

  task automatic idle(input bit c, input bit s, input bit f);
    ms_i_ce = c; ms_i_stall = s; ms_i_flush = f;
    ms_i_opcode = 7'($urandom); ms_i_funct3 = 3'($urandom); ms_i_alu_value = $urandom;
    ms_i_data_rs2 = $urandom; ms_i_addr_rd = 5'($urandom); ms_i_we_reg = 1'($urandom);
    ms_i_ack = 1'($urandom); ms_i_rdata = $urandom;
    expect_quiet(s);
    tick();
  endtask

  // One instruction from acceptance to writeback; k = cycles until ack, flush_at = BUSY cycle
  // carrying a flush (0 = none), hold = DONE cycles under external stall, kill_done = flush in DONE.
  task automatic issue(input logic [6:0] op, input logic [2:0] fn, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] r, input bit w, input logic [31:0] word,
                       input int unsigned k, input int unsigned flush_at, input int unsigned hold,
                       input bit kill_done);
    bit ld, st, mis, flushed;
    ld = (op == OP_LOAD);
    st = (op == OP_STORE);
`ifdef MISALIGN_TRAP_EN
    mis = m_misaligned(ld, st, fn, a);
`else
    mis = 1'b0;
`endif
    flushed = 1'b0;
    ms_i_ce = 1; ms_i_stall = 0; ms_i_flush = 0;
    ms_i_opcode = op; ms_i_funct3 = fn; ms_i_alu_value = a; ms_i_data_rs2 = d;
    ms_i_addr_rd = r; ms_i_we_reg = w;
    ms_i_ack = 1'($urandom); ms_i_rdata = $urandom;
    expect_quiet(1'b0);
    tick();
    if ((ld || st) && !mis) begin
      for (int unsigned i = 1; i <= k; i++) begin
        ms_i_flush = (i == flush_at);
        ms_i_ack   = (i == k);
        ms_i_rdata = (i == k) ? word : $urandom;
        if (i == flush_at) flushed = 1'b1;
        expect_quiet(1'b1);
        exp_req = 1; exp_maddr = a & ~32'd3; exp_mwe = st;
        exp_wdata = m_wdata(fn, d); exp_wsel = m_wsel(fn, a);
        pin_req_en = want_req; pin_st_en = want_st;
        tick();
      end
      pin_req_en = 0; pin_st_en = 0; ms_i_flush = 0; ms_i_ack = 0;
    end
    if (!flushed) begin
      for (int unsigned j = 0; j <= hold; j++) begin
        ms_i_stall = (j < hold);
        ms_i_flush = kill_done && (j == hold);
        ms_i_ack   = 1'($urandom);
        ms_i_rdata = $urandom;
        exp_stall = 1; exp_req = 0;
        exp_valid = !ms_i_flush;
        exp_we_reg = exp_valid && !mis && !st && w;
        exp_data_chk = exp_valid && !st && !mis;
        exp_data = ld ? m_load(word, fn, a) : a;
        exp_rd = r;
`ifdef MISALIGN_TRAP_EN
        exp_mis = mis;
`endif
        pin_data_en = want_data && exp_valid;
        tick();
      end
      pin_data_en = 0; ms_i_stall = 0; ms_i_flush = 0; ms_i_ack = 0;
    end
    ms_i_ce = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]  op;
    int unsigned sel, k, fa, hold;
    bit          kd, c, s, f;

    ms_rst = 0; ms_i_ce = 0; ms_i_stall = 0; ms_i_flush = 0; ms_i_ack = 0;
    ms_i_opcode = '0; ms_i_funct3 = '0; ms_i_alu_value = '0; ms_i_data_rs2 = '0;
    ms_i_addr_rd = '0; ms_i_we_reg = 0; ms_i_rdata = '0;
    expect_quiet(1'b0);
    tick(); tick(); tick();
    ms_rst = 1; exp_reset = 0;
    idle(0, 0, 0);

    want_data = 1; want_data_val = 32'h00000025;
    issue(OP_ADD, 3'd0, 32'h25, 32'h0, 5'd5, 1, 32'h0, 0, 0, 0, 0);
    want_data_val = 32'hFFFFFF80;
    issue(OP_LOAD, 3'd0, 32'h103, 32'h0, 5'd7, 1, 32'h80FF7F01, 3, 0, 0, 0);
    want_data_val = 32'h00000080;
    issue(OP_LOAD, 3'd4, 32'h103, 32'h0, 5'd8, 1, 32'h80FF7F01, 1, 0, 0, 0);
    want_data = 0;

    want_req = 1; want_addr = 32'h200; want_st = 1; want_wdata = 32'hABCDABCD; want_wsel = 4'b1100;
    issue(OP_STORE, 3'd1, 32'h202, 32'h1234ABCD, 5'd3, 1, 32'h0, 2, 0, 0, 0);
    want_req = 0; want_st = 0;

    issue(OP_LOAD, 3'd2, 32'h40, 32'h0, 5'd9, 1, 32'hDEADBEEF, 4, 2, 0, 0);
    issue(OP_ADD, 3'd0, 32'h77, 32'h0, 5'd10, 1, 32'h0, 0, 0, 0, 0);
    issue(OP_LOAD, 3'd2, 32'h44, 32'h0, 5'd11, 1, 32'h12345678, 1, 1, 0, 0);

`ifndef MISALIGN_TRAP_EN
    want_req = 1; want_addr = 32'h4;
`endif
    issue(OP_LOAD, 3'd2, 32'h6, 32'h0, 5'd12, 1, 32'hCAFEF00D, 2, 0, 0, 0);
    want_req = 0;

    issue(OP_ADD, 3'd0, 32'h99, 32'h0, 5'd13, 1, 32'h0, 0, 0, 0, 1);
    issue(OP_LOAD, 3'd1, 32'h12, 32'h0, 5'd14, 1, 32'h8001_7FFF, 1, 0, 2, 0);
    idle(1, 1, 0);
    idle(1, 0, 1);
    idle(0, 0, 0);

    // Mid-transaction reset: the request must collapse immediately.
    ms_i_ce = 1; ms_i_opcode = OP_LOAD; ms_i_funct3 = 3'd2; ms_i_alu_value = 32'h80;
    ms_i_addr_rd = 5'd4; ms_i_we_reg = 1; ms_i_ack = 0;
    expect_quiet(1'b0);
    tick();
    expect_quiet(1'b1);
    exp_req = 1; exp_maddr = 32'h80; exp_mwe = 0;
    tick();
    ms_rst = 0; ms_i_ce = 0; exp_reset = 1;
    tick(); tick();
    ms_rst = 1; exp_reset = 0;
    idle(0, 0, 0);
    issue(OP_ADD, 3'd0, 32'h1234, 32'h0, 5'd1, 1, 32'h0, 0, 0, 0, 0);

    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       op = OP_LOAD;
        1:       op = OP_STORE;
        2:       op = OP_ADD;
        default: op = 7'b0010011;
      endcase
      k    = $urandom_range(1, 4);
      fa   = ($urandom_range(0, 9) == 0) ? $urandom_range(1, k) : 0;
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      kd   = ($urandom_range(0, 9) == 0);
      issue(op, 3'($urandom), $urandom, $urandom, 5'($urandom), 1'($urandom), $urandom, k, fa, hold, kd);
      if ($urandom_range(0, 2) == 0) begin
        c = 1'($urandom);
        s = 1'($urandom);
        f = c ? (!s || 1'($urandom)) : 1'($urandom);
        idle(c, s, f);
      end
    end
    idle(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline stage directly downstream of `fetch_execute`. It takes the execute result (ALU value, opcode, funct3, rs2 data, rd address, register write enable) and performs RV32I loads and stores against a single-port data memory using a req/ack handshake. It then presents the writeback payload (rd address, rd data, write enable, valid) to the register-file writeback. It backpressures execute with a stall while a memory transaction is outstanding.

## Interface
Parameters:
- `DWIDTH`, 32: data/address width; only 32 is supported (byte-lane logic).
- `AWIDTH`, 5: register address width.
- `FUNCT_WIDTH`, 3: funct3 width.

Ports (name, direction, width, meaning):
- `ms_clk`, in, 1: clock; all state updates on the rising edge.
- `ms_rst`, in, 1: asynchronous, active-low reset.
- `ms_i_ce`, in, 1: clock enable / stage-valid from execute.
- `ms_i_stall`, in, 1: external stall from downstream; holds the stage.
- `ms_i_flush`, in, 1: kill the current and incoming instruction.
- `ms_i_opcode`, in, 7: RISC-V opcode field. Load = 7'b0000011, store = 7'b0100011; anything else passes through.
- `ms_i_funct3`, in, FUNCT_WIDTH: access size/sign.
- `ms_i_alu_value`, in, DWIDTH: ALU result, used as the effective address for memory ops and as the rd data otherwise.
- `ms_i_data_rs2`, in, DWIDTH: store data.
- `ms_i_addr_rd`, in, AWIDTH: destination register.
- `ms_i_we_reg`, in, 1: register write enable from decode.
- `ms_o_req`, out, 1: memory request.
- `ms_o_we`, out, 1: 1 = write.
- `ms_o_addr`, out, DWIDTH: word-aligned address `{alu[31:2],2'b00}`.
- `ms_o_wdata`, out, DWIDTH: lane-replicated store data.
- `ms_o_wsel`, out, 4: byte enables.
- `ms_i_ack`, in, 1: memory completion; valid only while `ms_o_req` is high.
- `ms_i_rdata`, in, DWIDTH: read data; valid in the cycle `ms_i_ack` is high.
- `ms_o_valid`, out, 1: writeback payload valid.
- `ms_o_we_reg`, out, 1: register write enable to writeback.
- `ms_o_addr_rd`, out, AWIDTH: writeback register address.
- `ms_o_data_rd`, out, DWIDTH: writeback data.
- `ms_o_ce`, out, 1: clock enable forwarded to writeback.
- `ms_o_stall`, out, 1: stall to execute; combinational `ms_i_stall | (state != IDLE)`.
- `ms_o_misaligned`, out, 1: misaligned-access flag. Present only under `MISALIGN_TRAP_EN`.

## Operation
- FSM states: IDLE, BUSY, DONE.
- Accept when `ms_i_ce & !ms_o_stall & !ms_i_flush` in IDLE.
- Non-memory op: register the payload and go to DONE. `data_rd = alu_value`, `we_reg = ms_i_we_reg`.
- Load or store: latch the fields, drive `ms_o_req=1` registered, and go to BUSY. `ms_o_req`, `ms_o_we`, `ms_o_addr`, `ms_o_wdata` and `ms_o_wsel` stay stable until ack.
- BUSY + `ms_i_ack`: drop req, format the result and go to DONE.
  - Load: `we_reg` = latched `we_reg`.
  - Store: `we_reg = 0`, `valid = 1`.
- DONE: outputs valid for one cycle, then return to IDLE. If `ms_i_stall` is high, hold DONE and keep the outputs.
- Store data and enables (`lane = addr[1:0]`):
  - funct3 000 (SB): `wdata = {4{rs2[7:0]}}`, `wsel = 4'b0001<<lane`.
  - funct3 001 (SH): `wdata = {2{rs2[15:0]}}`, `wsel = 4'b0011<<{addr[1],1'b0}`.
  - Any other funct3: `wsel = 4'b1111`.
- Load formatting:
  - 000 LB: sign-extend byte `lane`.
  - 100 LBU: zero-extend byte `lane`.
  - 001 LH: sign-extend half `addr[1]`.
  - 101 LHU: zero-extend half `addr[1]`.
  - Others: full word.
- Flush:
  - In IDLE: the incoming instruction is dropped.
  - In BUSY: req is held until ack (the bus transaction always completes), then the result is discarded (`valid=0`, `we_reg=0`) and the FSM returns to IDLE.
  - In DONE: `valid` and `we_reg` are forced to 0 in that cycle.

## Timing
- Reset (async, `ms_rst=0`): every output is 0, including `ms_o_req`, `ms_o_valid`, `ms_o_we_reg`, `ms_o_data_rd`, `ms_o_addr_rd`, `ms_o_wsel`, `ms_o_ce` and `ms_o_misaligned`. FSM goes to IDLE.
- Reset mid-transaction aborts req immediately; the memory must tolerate a dropped req.
- Non-memory latency: accepted at edge N, `ms_o_valid=1` after edge N, so 1 cycle.
- Memory op: accepted at edge N; `ms_o_req=1` after N; ack sampled at edge N+k (k≥1); `ms_o_valid=1` after edge N+k. Minimum load/store latency is 2 cycles.
- `ms_o_stall` is high from the cycle after accept until the DONE cycle ends. Execute holds its outputs while stall is high.
- Ack while req is low is ignored.
- Back-to-back: the next instruction is accepted in the first IDLE cycle after DONE.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - LH/LHU/SH with `addr[0]=1`, or LW/SW with `addr[1:0]!=0`, issues no req.
  - The FSM goes straight to DONE with `valid=1`, `we_reg=0`, `ms_o_misaligned=1` for that one cycle.
- Not defined: no `ms_o_misaligned` port. Low address bits beyond the access size are ignored: half uses `addr[1]`, word uses `addr[31:2]`.

## Test plan
- Reset: hold `ms_rst=0` for 2 cycles mid-BUSY -> all outputs 0, req drops immediately, FSM in IDLE.
- ADD pass-through: opcode 0110011, alu=0x00000025, rd=5, we=1 -> 1 cycle later `valid=1`, `data_rd=0x25`, `addr_rd=5`, no req.
- LB with rdata=0x80FF7F01, addr=0x103, ack 3 cycles after req -> `data_rd=0xFFFFFF80`, `ms_o_stall` high 4 cycles. LBU at the same address -> 0x00000080.
- SH with rs2=0x1234ABCD, addr=0x202 -> `ms_o_addr=0x200`, `wdata=0xABCDABCD`, `wsel=4'b1100`, `we=1`; then `valid=1`, `we_reg=0`.
- Flush in BUSY on an LW -> req held until ack, then `valid=0`, `we_reg=0`; next ADD accepted normally.
- `MISALIGN_TRAP_EN`: LW addr=0x6 -> no req, `ms_o_misaligned=1` for one cycle, `we_reg=0`. Without the macro -> `ms_o_addr=0x4`, normal load.
